cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Schedules the single common data bus (CDB) write-back path shared by three producers: ALU, LSB load results, and a planned MUL/DIV unit.
- Each producer has a small skid FIFO. A round-robin arbiter grants one result per cycle, and the result is broadcast registered to the ROB, RS and LSB.
- On a ROB branch-mispredict flush, all in-flight results are discarded.

Parameters:
- ROB_IDX_W, 4, width of the ROB index (matches ROB_SIZE_BIT).
- FIFO_DEPTH, 2, entries per source skid FIFO. Must be a power of 2 and at least 2.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-low.
- rdy_in  input  1  global enable; low freezes all state.
- rob_clear  input  1  mispredict flush.
- alu_valid  input  1  ALU result valid.
- alu_rob_idx  input  ROB_IDX_W  ALU result tag.
- alu_value  input  32  ALU result.
- alu_ready  output  1  ALU FIFO can accept.
- lsb_valid / lsb_rob_idx / lsb_value / lsb_ready  same widths and directions, LSB source.
- mul_valid / mul_rob_idx / mul_value / mul_ready  same widths and directions, MUL source.
- cdb_valid  output  1  broadcast valid.
- cdb_rob_idx  output  ROB_IDX_W  broadcast tag.
- cdb_value  output  32  broadcast value.
- cdb_src  output  2  granted source: 0 = ALU, 1 = LSB, 2 = MUL.

Behaviour:
- Reset (rst_in low, asynchronous):
  - all FIFOs empty, rr_ptr = 0;
  - cdb_valid = 0, cdb_rob_idx = 0, cdb_value = 0, cdb_src = 0;
  - all *_ready = 1 once reset is released.
- x_ready = (count_x < FIFO_DEPTH). It is a function of registered state only; it does not combinationally depend on x_valid.
- A push happens when x_valid && x_ready && rdy_in && !rob_clear. Valid while not ready is a protocol error; the input is dropped with no state change.
- Effective head of source x:
  - FIFO head if count_x > 0;
  - otherwise the incoming push (bypass);
  - otherwise nothing.
- Arbitration (combinational, over effective heads): the first requester found scanning rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3) wins.
  - On a grant to k: rr_ptr <= (k+1) mod 3.
  - With no requester, rr_ptr holds.
- Output register: on each enabled edge, cdb_valid <= any_grant. When a grant occurs, cdb_rob_idx, cdb_value and cdb_src load the granted head; otherwise they hold their old values.
- cdb_valid is a single-cycle pulse per result. Back-to-back grants give continuous valid.
- Latency: an input presented at cycle N with an empty FIFO and winning arbitration appears on the CDB at N+1. That is the minimum; maximum with FIFO full and contention is 3*FIFO_DEPTH cycles.
- FIFO update per source, per cycle:
  - push and head granted with count = 0: bypass, count unchanged (stays 0);
  - push and head granted with count > 0: pop and push, count unchanged;
  - push only: count+1;
  - grant only: count−1.
  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
- Ordering: results from one source leave in push order. There is no ordering across sources.
- rob_clear (sampled at an edge with rdy_in high):
  - all counts and pointers go to 0 and cdb_valid <= 0;
  - inputs in that cycle are discarded;
  - rr_ptr is unchanged;
  - a result already on the CDB this cycle is still visible this cycle (consumers also see rob_clear).
- rdy_in low: no push, pop, grant or rr_ptr change. cdb_* hold their values, including cdb_valid (consumers also gate on rdy_in). rob_clear is ignored while rdy_in is low.
- If rst_in is asserted mid-transfer, everything is discarded immediately and asynchronously.

Test Plan:
1. Reset, then alu_valid = 1, tag 3, value 0x12345678 in cycle N with FIFOs empty → cycle N+1: cdb_valid = 1, cdb_rob_idx = 3, cdb_value = 0x12345678, cdb_src = 0; cycle N+2: cdb_valid = 0.
2. All three sources valid in the same cycle, tags 1, 2, 3, rr_ptr = 0 → CDB shows tags 1, 2, 3 (src 0, 1, 2) on three consecutive cycles; rr_ptr ends at 0.
3. ALU pushes tags 4, 5, 6 on consecutive cycles while LSB pushes tags 8, 9, 10 (FIFO_DEPTH = 2) → grants alternate between ALU and LSB; alu_ready never deasserts falsely; per-source order is preserved (4, 5, 6 and 8, 9, 10); nothing is lost.
4. LSB held valid every cycle with the ALU blocked: fill until lsb_ready = 0 → lsb_ready goes low exactly when count reaches 2 and returns high the cycle after a pop.
5. FIFOs holding 2 ALU and 1 MUL entries, then rob_clear = 1 for one cycle → next cycle cdb_valid = 0, all *_ready = 1, and no stale tags ever appear afterwards.
6. rdy_in low for 3 cycles while cdb_valid = 1 (tag 7) with requests pending → cdb outputs frozen at tag 7; after rdy_in returns high, arbitration resumes from the same rr_ptr with no duplicated or skipped results.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Producer-side and broadcast-side signals of the common data bus arbiter.
// The slave modport is the arbiter; the master modport is the producer/consumer side.
interface cdb_arbiter_if #(
    parameter int ROB_IDX_W = 4
);
    logic                 alu_valid;
    logic [ROB_IDX_W-1:0] alu_rob_idx;
    logic [31:0]          alu_value;
    logic                 alu_ready;

    logic                 lsb_valid;
    logic [ROB_IDX_W-1:0] lsb_rob_idx;
    logic [31:0]          lsb_value;
    logic                 lsb_ready;

    logic                 mul_valid;
    logic [ROB_IDX_W-1:0] mul_rob_idx;
    logic [31:0]          mul_value;
    logic                 mul_ready;

    logic                 cdb_valid;
    logic [ROB_IDX_W-1:0] cdb_rob_idx;
    logic [31:0]          cdb_value;
    logic [1:0]           cdb_src;

    modport master (
        output alu_valid, alu_rob_idx, alu_value,
        output lsb_valid, lsb_rob_idx, lsb_value,
        output mul_valid, mul_rob_idx, mul_value,
        input  alu_ready, lsb_ready, mul_ready,
        input  cdb_valid, cdb_rob_idx, cdb_value, cdb_src
    );

    modport slave (
        input  alu_valid, alu_rob_idx, alu_value,
        input  lsb_valid, lsb_rob_idx, lsb_value,
        input  mul_valid, mul_rob_idx, mul_value,
        output alu_ready, lsb_ready, mul_ready,
        output cdb_valid, cdb_rob_idx, cdb_value, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin write-back arbiter for the shared CDB: three sources, each with a
// skid FIFO plus same-cycle bypass, one registered broadcast per cycle.
module cdb_arbiter #(
    parameter int ROB_IDX_W  = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    input  logic         rob_clear,
    cdb_arbiter_if.slave bus
);
    localparam int NSRC  = 3;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ROB_IDX_W + 32;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [NSRC-1:0]      in_valid;
    logic [ENT_W-1:0]     in_ent   [NSRC];
    logic [NSRC-1:0]      ready;
    logic [NSRC-1:0]      push;
    logic [NSRC-1:0]      req;
    logic [NSRC-1:0]      store;
    logic [NSRC-1:0]      pop;
    logic [ENT_W-1:0]     head     [NSRC];

    logic [ENT_W-1:0]     mem_q    [NSRC][FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q [NSRC];
    logic [PTR_W-1:0]     wr_ptr_d [NSRC];
    logic [PTR_W-1:0]     rd_ptr_q [NSRC];
    logic [PTR_W-1:0]     rd_ptr_d [NSRC];
    logic [CNT_W-1:0]     cnt_q    [NSRC];
    logic [CNT_W-1:0]     cnt_d    [NSRC];

    logic [1:0]           rr_q, rr_d;
    logic [1:0]           cand0, cand1, cand2;
    logic                 gnt_any;
    logic [1:0]           gnt_src;
    logic [NSRC-1:0]      gnt;

    logic                 cdb_valid_q;
    logic [ROB_IDX_W-1:0] cdb_rob_idx_q;
    logic [31:0]          cdb_value_q;
    logic [1:0]           cdb_src_q;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    assign in_valid  = {bus.mul_valid, bus.lsb_valid, bus.alu_valid};
    assign in_ent[0] = {bus.alu_rob_idx, bus.alu_value};
    assign in_ent[1] = {bus.lsb_rob_idx, bus.lsb_value};
    assign in_ent[2] = {bus.mul_rob_idx, bus.mul_value};

    // Effective head is the stored entry if any, else the same-cycle push.
    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            ready[s] = (cnt_q[s] < DEPTH_C);
            push[s]  = in_valid[s] && ready[s] && rdy_in && !rob_clear;
            req[s]   = (cnt_q[s] != '0) || push[s];
            head[s]  = (cnt_q[s] != '0) ? mem_q[s][rd_ptr_q[s]] : in_ent[s];
        end
    end

    always_comb begin
        cand0   = rr_q;
        cand1   = inc3(rr_q);
        cand2   = inc3(cand1);
        gnt_any = 1'b1;
        gnt_src = cand0;
        if (req[cand0])      gnt_src = cand0;
        else if (req[cand1]) gnt_src = cand1;
        else if (req[cand2]) gnt_src = cand2;
        else                 gnt_any = 1'b0;
        if (!rdy_in || rob_clear) gnt_any = 1'b0;
        gnt = '0;
        if (gnt_any) gnt[gnt_src] = 1'b1;
        rr_d = gnt_any ? inc3(gnt_src) : rr_q;
    end

    // A granted push into an empty FIFO is a pure bypass and never lands in storage.
    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            pop[s]      = gnt[s] && (cnt_q[s] != '0);
            store[s]    = push[s] && !(gnt[s] && (cnt_q[s] == '0));
            cnt_d[s]    = cnt_q[s];
            wr_ptr_d[s] = wr_ptr_q[s];
            rd_ptr_d[s] = rd_ptr_q[s];
            if (rdy_in && rob_clear) begin
                cnt_d[s]    = '0;
                wr_ptr_d[s] = '0;
                rd_ptr_d[s] = '0;
            end else begin
                if (store[s]) wr_ptr_d[s] = wr_ptr_q[s] + PTR_W'(1);
                if (pop[s])   rd_ptr_d[s] = rd_ptr_q[s] + PTR_W'(1);
                case ({store[s], pop[s]})
                    2'b10:   cnt_d[s] = cnt_q[s] + CNT_W'(1);
                    2'b01:   cnt_d[s] = cnt_q[s] - CNT_W'(1);
                    default: cnt_d[s] = cnt_q[s];
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        for (int s = 0; s < NSRC; s++) begin
            if (store[s]) mem_q[s][wr_ptr_q[s]] <= in_ent[s];
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int s = 0; s < NSRC; s++) begin
                cnt_q[s]    <= '0;
                wr_ptr_q[s] <= '0;
                rd_ptr_q[s] <= '0;
            end
            rr_q          <= 2'd0;
            cdb_valid_q   <= 1'b0;
            cdb_rob_idx_q <= '0;
            cdb_value_q   <= '0;
            cdb_src_q     <= 2'd0;
        end else begin
            for (int s = 0; s < NSRC; s++) begin
                cnt_q[s]    <= cnt_d[s];
                wr_ptr_q[s] <= wr_ptr_d[s];
                rd_ptr_q[s] <= rd_ptr_d[s];
            end
            rr_q <= rr_d;
            // Broadcast holds, valid included, while the pipeline is frozen.
            if (rdy_in) begin
                cdb_valid_q <= gnt_any;
                if (gnt_any) begin
                    cdb_rob_idx_q <= head[gnt_src][ENT_W-1:32];
                    cdb_value_q   <= head[gnt_src][31:0];
                    cdb_src_q     <= gnt_src;
                end
            end
        end
    end

    assign bus.alu_ready   = ready[0];
    assign bus.lsb_ready   = ready[1];
    assign bus.mul_ready   = ready[2];
    assign bus.cdb_valid   = cdb_valid_q;
    assign bus.cdb_rob_idx = cdb_rob_idx_q;
    assign bus.cdb_value   = cdb_value_q;
    assign bus.cdb_src     = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: hand-derived grant sequences for bypass,
// round-robin, FIFO fill/drop, flush, freeze and asynchronous reset.
module tb_cdb_arbiter;
    logic clk_in;
    logic rst_in;
    logic rdy_in;
    logic rob_clear;
    int   n_chk;
    int   n_fail;

    cdb_arbiter_if #(.ROB_IDX_W(4)) bus ();

    cdb_arbiter #(.ROB_IDX_W(4), .FIFO_DEPTH(2)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .rob_clear (rob_clear),
        .bus       (bus.slave)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] vf(input logic [3:0] t);
        return {28'h5A5A5A0, t};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic av, input logic [3:0] at,
                         input logic lv, input logic [3:0] lt,
                         input logic mv, input logic [3:0] mt);
        bus.alu_valid = av; bus.alu_rob_idx = at; bus.alu_value = vf(at);
        bus.lsb_valid = lv; bus.lsb_rob_idx = lt; bus.lsb_value = vf(lt);
        bus.mul_valid = mv; bus.mul_rob_idx = mt; bus.mul_value = vf(mt);
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    endtask

    task automatic expect_out(input string nm, input logic [3:0] idx, input logic [1:0] src);
        chk({nm, "_valid"}, 64'(bus.cdb_valid), 64'd1);
        chk({nm, "_idx"},   64'(bus.cdb_rob_idx), 64'(idx));
        chk({nm, "_value"}, 64'(bus.cdb_value), 64'(vf(idx)));
        chk({nm, "_src"},   64'(bus.cdb_src), 64'(src));
    endtask

    task automatic expect_idle(input string nm);
        chk({nm, "_valid"}, 64'(bus.cdb_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] t3_alu [3];
        logic [3:0] t3_lsb [3];
        logic [3:0] t3_out [6];
        logic [3:0] t4_out [7];
        logic       t4_lrdy [4];

        n_chk = 0;
        n_fail = 0;
        rst_in = 1'b0;
        rdy_in = 1'b1;
        rob_clear = 1'b0;
        idle();

        // Reset state
        #12;
        chk("rst_valid", 64'(bus.cdb_valid), 64'd0);
        chk("rst_idx",   64'(bus.cdb_rob_idx), 64'd0);
        chk("rst_value", 64'(bus.cdb_value), 64'd0);
        chk("rst_src",   64'(bus.cdb_src), 64'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        step();
        chk("rst_alu_rdy", 64'(bus.alu_ready), 64'd1);
        chk("rst_lsb_rdy", 64'(bus.lsb_ready), 64'd1);
        chk("rst_mul_rdy", 64'(bus.mul_ready), 64'd1);

        // Single ALU result bypasses straight onto the CDB
        bus.alu_valid = 1'b1; bus.alu_rob_idx = 4'd3; bus.alu_value = 32'h12345678;
        step();
        idle();
        chk("t1_valid", 64'(bus.cdb_valid), 64'd1);
        chk("t1_idx",   64'(bus.cdb_rob_idx), 64'd3);
        chk("t1_value", 64'(bus.cdb_value), 64'h12345678);
        chk("t1_src",   64'(bus.cdb_src), 64'd0);
        step();
        expect_idle("t1_pulse");

        // rr_ptr is 1; a lone MUL grant brings it back to 0
        drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd0);
        step();
        idle();
        expect_out("sync", 4'd0, 2'd2);

        // All three sources in one cycle, rr_ptr = 0
        drive(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3);
        step();
        idle();
        expect_out("t2_a", 4'd1, 2'd0);
        step();
        expect_out("t2_b", 4'd2, 2'd1);
        step();
        expect_out("t2_c", 4'd3, 2'd2);
        step();
        expect_idle("t2_end");

        // ALU 4,5,6 against LSB 8,9,10 from rr_ptr = 0
        t3_alu = '{4'd4, 4'd5, 4'd6};
        t3_lsb = '{4'd8, 4'd9, 4'd10};
        t3_out = '{4'd4, 4'd8, 4'd5, 4'd9, 4'd6, 4'd10};
        for (int i = 0; i < 6; i++) begin
            if (i < 3) begin
                chk($sformatf("t3_alu_rdy%0d", i), 64'(bus.alu_ready), 64'd1);
                chk($sformatf("t3_lsb_rdy%0d", i), 64'(bus.lsb_ready), 64'd1);
                drive(1'b1, t3_alu[i], 1'b1, t3_lsb[i], 1'b0, 4'd0);
            end else begin
                idle();
            end
            step();
            idle();
            expect_out($sformatf("t3_out%0d", i), t3_out[i], 2'(i % 2));
        end
        step();
        expect_idle("t3_end");

        // LSB held valid against a busy ALU from rr_ptr = 2; tag 12 arrives while full
        t4_lrdy = '{1'b1, 1'b1, 1'b0, 1'b1};
        t4_out  = '{4'd1, 4'd9, 4'd2, 4'd10, 4'd3, 4'd11, 4'd4};
        for (int i = 0; i < 7; i++) begin
            if (i < 4) drive(1'b1, 4'(i + 1), 1'b1, 4'(i + 9), 1'b0, 4'd0);
            else       idle();
            step();
            idle();
            expect_out($sformatf("t4_out%0d", i), t4_out[i], 2'(i % 2));
            if (i < 4)
                chk($sformatf("t4_lsb_rdy%0d", i), 64'(bus.lsb_ready), 64'(t4_lrdy[i]));
            if (i == 3)
                chk("t4_alu_full", 64'(bus.alu_ready), 64'd0);
        end
        step();
        expect_idle("t4_end");
        step();
        expect_idle("t4_no_drop");

        // Build up 2 ALU and 1 MUL entries from rr_ptr = 1, then flush
        drive(1'b1, 4'd5, 1'b0, 4'd0, 1'b1, 4'd6);
        step();
        expect_out("t5_p1", 4'd6, 2'd2);
        drive(1'b1, 4'd7, 1'b0, 4'd0, 1'b1, 4'd8);
        step();
        expect_out("t5_p2", 4'd5, 2'd0);
        drive(1'b1, 4'd9, 1'b0, 4'd0, 1'b1, 4'd10);
        step();
        expect_out("t5_p3", 4'd8, 2'd2);
        chk("t5_alu_full", 64'(bus.alu_ready), 64'd0);
        drive(1'b0, 4'd0, 1'b1, 4'd13, 1'b1, 4'd12);
        rob_clear = 1'b1;
        #1;
        expect_out("t5_visible", 4'd8, 2'd2);
        step();
        rob_clear = 1'b0;
        idle();
        expect_idle("t5_flush");
        chk("t5_alu_rdy", 64'(bus.alu_ready), 64'd1);
        chk("t5_lsb_rdy", 64'(bus.lsb_ready), 64'd1);
        chk("t5_mul_rdy", 64'(bus.mul_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_idle($sformatf("t5_stale%0d", i));
        end
        drive(1'b0, 4'd0, 1'b1, 4'd13, 1'b0, 4'd0);
        step();
        idle();
        expect_out("t5_after", 4'd13, 2'd1);
        step();
        expect_idle("t5_end");

        // Freeze with tag 7 on the bus and LSB 14 / MUL 16 pending at rr_ptr = 1
        drive(1'b1, 4'd7, 1'b1, 4'd14, 1'b1, 4'd15);
        step();
        expect_out("t6_q0", 4'd15, 2'd2);
        drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd16);
        step();
        expect_out("t6_q1", 4'd7, 2'd0);
        drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd1);
        rdy_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rob_clear = (k == 1);
            step();
            expect_out($sformatf("t6_frz%0d", k), 4'd7, 2'd0);
        end
        rob_clear = 1'b0;
        rdy_in = 1'b1;
        idle();
        step();
        expect_out("t6_r1", 4'd14, 2'd1);
        step();
        expect_out("t6_r2", 4'd16, 2'd2);
        step();
        expect_idle("t6_r3");
        step();
        expect_idle("t6_r4");

        // Asynchronous reset mid-transfer discards bus and pending LSB entry
        drive(1'b1, 4'd2, 1'b1, 4'd3, 1'b0, 4'd0);
        step();
        idle();
        expect_out("ar_pre", 4'd2, 2'd0);
        #2;
        rst_in = 1'b0;
        #1;
        chk("ar_valid", 64'(bus.cdb_valid), 64'd0);
        chk("ar_idx",   64'(bus.cdb_rob_idx), 64'd0);
        chk("ar_lsb_rdy", 64'(bus.lsb_ready), 64'd1);
        #2;
        rst_in = 1'b1;
        step();
        expect_idle("ar_post0");
        step();
        expect_idle("ar_post1");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
